// File: rtl/armleocpu_defs.sv
// rtl/armleocpu_defs.sv - shared load/store type encodings and store-queue entry type
//
// Purpose: funct3 encodings for loads and stores used across the memory
// pipeline, plus the packed layout of one store-queue entry.
// Ports: none (package).

package armleocpu_defs;

  // Load encodings (funct3)
  localparam logic [2:0] LOAD_BYTE          = 3'b000;
  localparam logic [2:0] LOAD_HALF          = 3'b001;
  localparam logic [2:0] LOAD_WORD          = 3'b010;
  localparam logic [2:0] LOAD_BYTE_UNSIGNED = 3'b100;
  localparam logic [2:0] LOAD_HALF_UNSIGNED = 3'b101;

  // Store encodings (funct3)
  localparam logic [2:0] STORE_BYTE = 3'b000;
  localparam logic [2:0] STORE_HALF = 3'b001;
  localparam logic [2:0] STORE_WORD = 3'b010;

  // One queued write, already lane-positioned so the memory side never
  // has to look at the original request again.
  typedef struct packed {
    logic [29:0] wordAddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } storeEntry_t;

endpackage

// File: rtl/armleocpu_store_unit_if.sv
// rtl/armleocpu_store_unit_if.sv - request and memory-write handshake bundle
//
// Purpose: groups the store request channel (core -> unit) and the memory
// write channel (unit -> memory).
// Signals:
//   req_valid/req_ready/req_addr/req_type/req_data : store request handshake
//   mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb : word write to memory
// Modports:
//   master : the core/memory side (drives requests, accepts writes)
//   slave  : the store unit

interface armleocpu_store_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [31:0] req_data;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport master (
    output req_valid,
    input  req_ready,
    output req_addr,
    output req_type,
    output req_data,
    input  mem_valid,
    output mem_ready,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_addr,
    input  req_type,
    input  req_data,
    output mem_valid,
    input  mem_ready,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb
  );

endinterface

// File: rtl/armleocpu_storegen.sv
// rtl/armleocpu_storegen.sv - combinational lane, strobe and error generation for stores
//
// Purpose: turns a right-aligned store request into lane-positioned write
// data and byte strobes, and classifies it as unknown or misaligned.
// Ports:
//   addrLow     in  2   low address bits (byte offset within the word)
//   storeType   in  3   funct3 store type
//   storeData   in  32  right-aligned store data
//   wdata       out 32  data shifted into its byte lanes
//   wstrb       out 4   byte-lane enables
//   misaligned  out 1   known type whose address is not naturally aligned
//   unknownType out 1   storeType is not byte/half/word

module armleocpu_storegen
  import armleocpu_defs::*;
(
  input  logic [1:0]  addrLow,
  input  logic [2:0]  storeType,
  input  logic [31:0] storeData,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic        unknownType
);

  always_comb begin
    wstrb       = 4'b0000;
    misaligned  = 1'b0;
    unknownType = 1'b0;
    // Shift regardless of type so unused lanes are still deterministic.
    wdata       = storeData << {addrLow, 3'b000};
    case (storeType)
      STORE_BYTE: begin
        wstrb = 4'b0001 << addrLow;
      end
      STORE_HALF: begin
        wstrb      = 4'b0011 << addrLow;
        misaligned = addrLow[0];
      end
      STORE_WORD: begin
        wstrb      = 4'b1111;
        misaligned = (addrLow != 2'b00);
      end
      default: begin
        // Unknown type wins; misaligned stays low.
        unknownType = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/armleocpu_store_unit.sv
// rtl/armleocpu_store_unit.sv - store queue between the core and the memory write port
//
// Purpose: accepts store requests, rejects unknown/misaligned ones with a
// one-cycle error pulse, and queues the rest as word writes drained in order.
// Ports:
//   clk                in  1  clock, rising edge
//   rst                in  1  asynchronous active-high reset
//   bus                slave  request and memory-write handshakes
//   store_missaligned  out 1  pulse the cycle after a misaligned store is accepted
//   store_unknown_type out 1  pulse the cycle after an unknown-type store is accepted
//   store_empty        out 1  queue holds no pending writes

module armleocpu_store_unit
  import armleocpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  armleocpu_store_unit_if.slave bus,
  output logic                 store_missaligned,
  output logic                 store_unknown_type,
  output logic                 store_empty
);

  // DEPTH must be a power of two so the pointers wrap by plain overflow.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W:0]   count;

  logic full;
  logic empty;
  logic accept;
  logic push;
  logic pop;

  logic [31:0] genWdata;
  logic [3:0]  genWstrb;
  logic        genMisaligned;
  logic        genUnknown;

  storeEntry_t entries [DEPTH];
  storeEntry_t headEntry;

  armleocpu_storegen u_storegen (
    .addrLow     (bus.req_addr[1:0]),
    .storeType   (bus.req_type),
    .storeData   (bus.req_data),
    .wdata       (genWdata),
    .wstrb       (genWstrb),
    .misaligned  (genMisaligned),
    .unknownType (genUnknown)
  );

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // Ready depends only on occupancy, so a pop in the same cycle never
  // opens a slot for a request while full.
  assign bus.req_ready = !full;
  assign accept        = bus.req_valid && !full;
  assign push          = accept && !genMisaligned && !genUnknown;
  assign pop           = !empty && bus.mem_ready;

  assign store_empty   = empty;
  assign bus.mem_valid = !empty;

  assign headEntry     = entries[rdPtr];
  assign bus.mem_addr  = {headEntry.wordAddr, 2'b00};
  assign bus.mem_wdata = headEntry.wdata;
  assign bus.mem_wstrb = headEntry.wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr              <= '0;
      wrPtr              <= '0;
      count              <= '0;
      store_missaligned  <= 1'b0;
      store_unknown_type <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      store_missaligned  <= accept && genMisaligned;
      store_unknown_type <= accept && genUnknown;
    end
  end

  // Entry payload needs no reset: it is only observed while count says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wrPtr] <= '{wordAddr: bus.req_addr[31:2], wdata: genWdata, wstrb: genWstrb};
    end
  end

endmodule

// File: tb/tb_armleocpu_store_unit.sv
// tb/tb_armleocpu_store_unit.sv - scoreboard bench for the store unit

module tb_armleocpu_store_unit;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } expWrite_t;

  logic clk = 1'b0;
  logic rst;
  logic store_missaligned;
  logic store_unknown_type;
  logic store_empty;

  armleocpu_store_unit_if bus ();

  armleocpu_store_unit #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .store_missaligned  (store_missaligned),
    .store_unknown_type (store_unknown_type),
    .store_empty        (store_empty)
  );

  always #5 clk = ~clk;

  int assertionsEvaluated = 0;
  int failures = 0;

  expWrite_t expQ[$];
  bit expMisNext = 0;
  bit expUnkNext = 0;
  bit accFlag = 0;
  int popCount = 0;
  int misCount = 0;
  int unkCount = 0;
  int mrMode = 1;
  int mrHold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertionsEvaluated++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: natural-size store into a little-endian 4-byte word.
  function automatic void modelStore(input logic [31:0] addr, input logic [2:0] t,
                                     input logic [31:0] data, output bit unk,
                                     output bit mis, output expWrite_t w);
    int off;
    int size;
    off  = int'(addr % 4);
    unk  = 0;
    mis  = 0;
    size = 0;
    case (t)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      default: unk = 1;
    endcase
    if (!unk && (off % size) != 0) mis = 1;
    w.addr  = addr - 32'(off);
    w.wstrb = 4'(((1 << size) - 1) << off);
    w.wdata = data << (8 * off);
  endfunction

  // Memory-side ready generator: 0 low, 1 high, 2 random; mrHold forces low.
  always @(negedge clk) begin
    if (mrHold > 0) begin
      mrHold--;
      bus.mem_ready = 1'b0;
    end else begin
      case (mrMode)
        0:       bus.mem_ready = 1'b0;
        1:       bus.mem_ready = 1'b1;
        default: bus.mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor just before each rising edge: handshakes, head contents, acceptance.
  always @(negedge clk) begin
    expWrite_t e;
    expWrite_t w;
    bit unk;
    bit mis;
    bit expReady;
    logic [31:0] mask;
    #4;
    accFlag = 0;
    if (rst) begin
      expQ.delete();
      expMisNext = 0;
      expUnkNext = 0;
      check("mem_valid_in_reset", 32'(bus.mem_valid), 32'd0);
    end else begin
      expReady = (expQ.size() < DEPTH);
      check("req_ready", 32'(bus.req_ready), 32'(expReady));
      check("mem_valid", 32'(bus.mem_valid), 32'(expQ.size() != 0));
      check("store_empty", 32'(store_empty), 32'(expQ.size() == 0));
      if (expQ.size() != 0 && bus.mem_ready === 1'b1) begin
        e = expQ.pop_front();
        for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{e.wstrb[i]}};
        check("mem_addr", bus.mem_addr, e.addr);
        check("mem_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
        check("mem_wdata_lanes", bus.mem_wdata & mask, e.wdata & mask);
        popCount++;
      end
      expMisNext = 0;
      expUnkNext = 0;
      if (bus.req_valid && expReady) begin
        accFlag = 1;
        modelStore(bus.req_addr, bus.req_type, bus.req_data, unk, mis, w);
        if (unk) expUnkNext = 1;
        else if (mis) expMisNext = 1;
        else expQ.push_back(w);
      end
    end
  end

  // Error pulses are checked just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("store_missaligned", 32'(store_missaligned), 32'(expMisNext));
      check("store_unknown_type", 32'(store_unknown_type), 32'(expUnkNext));
      if (store_missaligned === 1'b1) misCount++;
      if (store_unknown_type === 1'b1) unkCount++;
    end
  end

  task automatic send(input logic [31:0] a, input logic [2:0] t, input logic [31:0] d,
                      output int waited);
    waited = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_type  = t;
    bus.req_data  = d;
    forever begin
      @(posedge clk);
      #1;
      if (accFlag) break;
      waited++;
      if (waited > 60) begin
        assertionsEvaluated++;
        failures++;
        $display("FAIL send_timeout: request %h not accepted after %0d cycles", a, waited);
        break;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w;
    int base;
    int r;
    int bound;
    logic [2:0] t;
    logic [31:0] a;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_type  = '0;
    bus.req_data  = '0;
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_store_empty", 32'(store_empty), 32'd1);
    check("reset_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("reset_missaligned", 32'(store_missaligned), 32'd0);
    check("reset_unknown", 32'(store_unknown_type), 32'd0);
    idle(2);
    #2 rst = 1'b0;
    mrMode = 1;
    idle(1);

    // Byte store into the top lane.
    send(32'h0000_1003, 3'b000, 32'h0000_00AB, w);
    check("byte_mem_valid_next", 32'(bus.mem_valid), 32'd1);
    check("byte_mem_addr", bus.mem_addr, 32'h0000_1000);
    check("byte_mem_wstrb", 32'(bus.mem_wstrb), 32'b1000);
    check("byte_mem_wdata_hi", 32'(bus.mem_wdata[31:24]), 32'hAB);

    // Misaligned half: error pulse, nothing queued.
    base = misCount;
    send(32'h0000_2001, 3'b001, 32'h0000_1234, w);
    check("half_mis_pulse", 32'(store_missaligned), 32'd1);
    check("half_mis_no_unknown", 32'(store_unknown_type), 32'd0);
    check("half_mis_no_write", 32'(bus.mem_valid), 32'd0);
    check("half_mis_empty", 32'(store_empty), 32'd1);
    @(posedge clk); #1;
    check("half_mis_pulse_ends", 32'(store_missaligned), 32'd0);
    check("half_mis_count", 32'(misCount - base), 32'd1);

    // Unknown type suppresses misaligned.
    base = unkCount;
    send(32'h0000_2001, 3'b111, 32'h0000_5678, w);
    check("unk_pulse", 32'(store_unknown_type), 32'd1);
    check("unk_no_mis", 32'(store_missaligned), 32'd0);
    check("unk_no_write", 32'(bus.mem_valid), 32'd0);
    @(posedge clk); #1;
    check("unk_pulse_ends", 32'(store_unknown_type), 32'd0);
    check("unk_count", 32'(unkCount - base), 32'd1);

    // Full queue with memory stalled; third request held until first pop.
    mrMode = 0;
    idle(1);
    send(32'h0000_0100, 3'b010, 32'h1111_1111, w);
    send(32'h0000_0104, 3'b010, 32'h2222_2222, w);
    check("full_req_ready_low", 32'(bus.req_ready), 32'd0);
    base = popCount;
    mrHold = 3;
    mrMode = 1;
    send(32'h0000_0108, 3'b010, 32'h3333_3333, w);
    check("third_held_cycles", 32'(w), 32'd4);
    check("third_after_first_pop", 32'(popCount - base), 32'd2);
    idle(3);
    check("full_drained", 32'(store_empty), 32'd1);

    // Back-to-back word stores with memory always ready.
    idle(1);
    base = popCount;
    for (int i = 0; i < 8; i++) begin
      send(32'h10 + 32'(4 * i), 3'b010, $urandom, w);
      check("b2b_no_stall", 32'(w), 32'd0);
    end
    idle(3);
    check("b2b_write_count", 32'(popCount - base), 32'd8);

    // Reset with two queued entries.
    mrMode = 0;
    idle(1);
    send(32'h0000_0200, 3'b010, 32'hAAAA_0001, w);
    send(32'h0000_0204, 3'b010, 32'hAAAA_0002, w);
    check("rst_pre_mem_valid", 32'(bus.mem_valid), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mem_valid_drop", 32'(bus.mem_valid), 32'd0);
    check("rst_store_empty", 32'(store_empty), 32'd1);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    mrMode = 1;
    @(negedge clk);
    #2 rst = 1'b0;
    base = popCount;
    idle(4);
    check("rst_no_writes_after", 32'(bus.mem_valid), 32'd0);
    check("rst_no_pops", 32'(popCount - base), 32'd0);

    // Randomized traffic against the scoreboard.
    mrMode = 2;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) t = 3'b000;
      else if (r < 6) t = 3'b001;
      else if (r < 9) t = 3'b010;
      else t = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (t == 3'b001) a[0] = 1'b0;
        if (t == 3'b010) a[1:0] = 2'b00;
      end
      send(a, t, $urandom, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    mrMode = 1;
    bound = 0;
    while (expQ.size() != 0 && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    idle(2);
    check("final_drain", 32'(expQ.size()), 32'd0);
    check("final_store_empty", 32'(store_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionsEvaluated, failures);
    $finish;
  end

endmodule

// File: doc/armleocpu_store_unit.md
ARMLEOCPU_STORE_UNIT -- requirements
Module: armleocpu_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, store-queue entries; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  store request present.
REQ-005 SHALL have port req_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have port req_addr  input  32  byte address of store.
REQ-007 SHALL have port req_type  input  3  store type (funct3 encoding).
REQ-008 SHALL have port req_data  input  32  store data, right-aligned.
REQ-009 SHALL have port mem_valid  output  1  write request to memory.
REQ-010 SHALL have port mem_ready  input  1  memory accepts write.
REQ-011 SHALL have port mem_addr  output  32  word-aligned write address.
REQ-012 SHALL have port mem_wdata  output  32  lane-positioned write data.
REQ-013 SHALL have port mem_wstrb  output  4  byte-lane write enables.
REQ-014 SHALL have port store_missaligned  output  1  one-cycle error pulse.
REQ-015 SHALL have port store_unknown_type  output  1  one-cycle error pulse.
REQ-016 SHALL have port store_empty  output  1  queue empty (fence/drain indicator).

Function
REQ-017 SHALL define handshakes as valid&&ready on rising edge; valid SHALL NOT depend combinationally on ready.
REQ-018 SHALL drive req_ready = !full; no push-through when full, even if pop occurs same cycle.
REQ-019 SHALL decode req_type: STORE_BYTE 3'b000, STORE_HALF 3'b001, STORE_WORD 3'b010; others unknown.
REQ-020 SHALL flag misaligned: half with addr[0]=1; word with addr[1:0]!=0; byte never.
REQ-021 SHALL, on accepted unknown/misaligned request, not enqueue and pulse the matching error output exactly the next cycle; unknown type suppresses misaligned.
REQ-022 SHALL generate wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-023 SHALL generate wdata = req_data << (8*addr[1:0]); unselected lanes don't-care but deterministic.
REQ-024 SHALL store {addr[31:2],2'b00, wdata, wstrb} per entry, computed at enqueue.
REQ-025 SHALL drive mem_valid = !empty, mem_* from head entry registers; earliest mem_valid one cycle after acceptance.
REQ-026 SHALL hold mem_addr/wdata/wstrb stable while mem_valid && !mem_ready.
REQ-027 SHALL pop head on mem_valid&&mem_ready; strict FIFO order.
REQ-028 SHALL support simultaneous push and pop when not full: count unchanged, both pointers advance.
REQ-029 SHALL use read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH and a count of $clog2(DEPTH)+1 bits; full = count==DEPTH, empty = count==0.
REQ-030 SHALL drive store_empty = empty, combinationally from count.
REQ-031 SHALL sustain one store per cycle throughput when mem_ready held high.

Reset
REQ-032 SHALL, while rst=1, asynchronously clear pointers, count, error pulses; mem_valid=0, store_empty=1, req_ready=1.
REQ-033 SHALL discard all queued entries on reset mid-operation; no memory write issued after reset asserts.
REQ-034 SHALL not require entry data storage to be reset.

Structure
REQ-035 SHALL take STORE_BYTE/STORE_HALF/STORE_WORD constants from shared armleocpu_defs, beside the load constants.
REQ-036 SHALL place lane/strobe/error generation in combinational sub-module armleocpu_storegen; queue and handshake in top.

Verification
REQ-037 SHALL test: byte store addr=0x1003 data=0xAB -> mem_addr 0x1000, wstrb 4'b1000, wdata[31:24]=0xAB, one cycle later.
REQ-038 SHALL test: half store addr=0x2001 -> store_missaligned pulse one cycle, no mem_valid, store_empty stays 1.
REQ-039 SHALL test: req_type 3'b111 addr=0x2001 -> store_unknown_type pulse only, no mem_valid.
REQ-040 SHALL test: mem_ready=0, two word stores -> req_ready=0 after second; third held; mem_ready=1 drains in order, third accepted after first pop.
REQ-041 SHALL test: mem_ready=1, back-to-back stores 0x10,0x14,0x18,... -> one write per cycle, order preserved, pointers wrap correctly.
REQ-042 SHALL test: rst asserted with 2 queued entries and mem_valid high -> mem_valid drops immediately, store_empty=1, no further writes.
